// File: rtl/fifo_pkg.sv
// Shared constants and small helpers for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int D_SIZE_DEF = 8;
  localparam int P_SIZE_DEF = 4;
  localparam int BUF_DEPTH  = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] lvl_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_t;

  // Pointers walk 0,1,2 and wrap; the buffer is not a power of two deep.
  function automatic ptr_t ptr_next(input ptr_t p);
    ptr_t n;
    if (p == ptr_t'(BUF_DEPTH - 1)) n = '0;
    else n = p + ptr_t'(1);
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry register FIFO holding words returned by the FIFO memory
// until the downstream stream interface accepts them.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              push,
  input  logic [D_SIZE-1:0] push_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  output lvl_t              count
);

  logic [D_SIZE-1:0] mem_reg [BUF_DEPTH];
  ptr_t              wr_ptr_reg;
  ptr_t              rd_ptr_reg;
  lvl_t              count_reg;
  logic              pop;
  logic              push_ok;
  buf_op_t           op;

  assign pop     = (count_reg != '0) && out_ready;
  assign push_ok = push && !flush;
  assign op      = buf_op_t'({push_ok, pop});

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == ptr_t'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Flush takes priority over any transfer in the same cycle.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_next(wr_ptr_reg);
      if (pop)     rd_ptr_reg <= ptr_next(rd_ptr_reg);
      case (op)
        OP_PUSH: count_reg <= count_reg + lvl_t'(1);
        OP_POP:  count_reg <= count_reg - lvl_t'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    out_data = mem_reg[0];
    case (rd_ptr_reg)
      2'd1:    out_data = mem_reg[1];
      2'd2:    out_data = mem_reg[2];
      default: out_data = mem_reg[0];
    endcase
  end

  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (
    @(posedge r_clk) disable iff (!r_rstn)
    !(push_ok && (count_reg == lvl_t'(BUF_DEPTH)))
  );
`endif

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: issues pops to the FIFO read-pointer stage and
// buffers the returned words behind a valid/ready interface.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int D_SIZE    = D_SIZE_DEF,
  parameter int BUF_DEPTH = fifo_pkg::BUF_DEPTH
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              empty,
  input  logic [D_SIZE-1:0] rd_data,
  output logic              r_inc,
  input  logic              flush,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_level
);

  logic pend_reg;
  lvl_t count;
  logic [2:0] committed;

  // Words already buffered plus the one still in flight from the memory.
  assign committed = {1'b0, count} + {2'b00, pend_reg};

  // Reset gates the request directly so no pop leaks out while held in reset.
  assign r_inc = r_rstn && !empty && !flush && (committed < 3'(BUF_DEPTH));

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= r_inc;
    end
  end

  fifo_rd_buf #(
    .D_SIZE (D_SIZE)
  ) u_buf (
    .r_clk     (r_clk),
    .r_rstn    (r_rstn),
    .push      (pend_reg && !flush),
    .push_data (rd_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count)
  );

  assign out_level = count;

`ifndef SYNTHESIS
  a_committed_bound: assert property (
    @(posedge r_clk) disable iff (!r_rstn)
    committed <= 3'(BUF_DEPTH)
  );
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter D_SIZE, default 8: data word width.
REQ-002 Parameter BUF_DEPTH, default 3: output buffer entries; fixed at 3, other values unsupported.
REQ-003 r_clk  in  1  read-domain clock; single clock, all logic on rising edge.
REQ-004 r_rstn  in  1  asynchronous active-low reset.
REQ-005 empty  in  1  FIFO empty flag from the read-pointer stage.
REQ-006 rd_data  in  D_SIZE  FIFO memory read data; valid exactly one r_clk cycle after r_inc was high.
REQ-007 r_inc  out  1  pop request to the read-pointer stage.
REQ-008 flush  in  1  synchronous discard of buffered and in-flight words.
REQ-009 out_data  out  D_SIZE  stream data, head of buffer.
REQ-010 out_valid  out  1  stream data valid.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 out_level  out  2  current buffer occupancy, 0..3.

Function
REQ-013 r_inc SHALL be combinational: !empty && !flush && (count + pend) < 3, where count = occupancy and pend = registered copy of the previous r_inc.
REQ-014 r_inc SHALL have no combinational path from out_ready.
REQ-015 When pend=1 and flush=0, rd_data SHALL be written into the buffer tail at the next edge.
REQ-016 A transfer SHALL occur on out_valid && out_ready and SHALL remove the head at that edge.
REQ-017 out_valid SHALL equal (count != 0), registered state only.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and SHALL preserve word order.
REQ-019 Buffer SHALL be strict FIFO order, with no drop and no duplication.
REQ-020 Latency: empty falls at cycle t, giving r_inc at t, capture at end of t+1, and out_valid at t+2.
REQ-021 With empty=0 and out_ready=1 held, throughput SHALL be one word per cycle after fill.
REQ-022 count+pend SHALL never exceed 3; push into a full buffer is impossible by construction, and an assertion SHALL check it.
REQ-023 out_ready low SHALL hold out_data and out_valid stable until transfer.
REQ-024 flush=1 SHALL clear count to 0 and discard a pending rd_data capture at that edge.
REQ-025 flush=1 SHALL force r_inc=0 in the same cycle.
REQ-026 flush and transfer in the same cycle: flush wins; the word counts as consumed by the downstream.
REQ-027 out_data SHALL be don't-care when out_valid=0, but SHALL NOT be X after reset.
REQ-028 out_level SHALL equal count.

Reset
REQ-029 r_rstn low SHALL asynchronously clear count, pend, and the buffer pointers, giving out_valid=0, out_level=0 and r_inc=0.
REQ-030 The buffer data registers SHALL reset to 0.
REQ-031 Reset mid-operation SHALL discard in-flight words; operation restarts cleanly.
REQ-032 Reset SHALL be released only with the read-pointer stage reset in the same domain.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the default D_SIZE and P_SIZE constants and the BUF_DEPTH constant.
REQ-034 One sub-module, fifo_rd_buf, SHALL implement the 3-entry register FIFO, including push, pop, count and flush.
REQ-035 The top level SHALL hold the pend register and the r_inc logic only.

Verification
REQ-036 Scenario: empty=0 from cycle 0, out_ready=1, and memory returns 0x01..0x08 -> r_inc high at cycle 0; out_data 0x01 valid at cycle 2; 0x02..0x08 follow on consecutive cycles.
REQ-037 Scenario: empty=0, out_ready=0 for 10 cycles -> exactly 3 r_inc pulses; out_level=3; out_data holds the first word.
REQ-038 Scenario: buffer full with 0xA0,0xA1,0xA2 and out_ready=1 for 1 cycle -> 0xA0 transferred and one new r_inc issued; order preserved.
REQ-039 Scenario: flush asserted in the cycle after r_inc, with data 0x55 returning -> 0x55 never appears; out_level=0; out_valid=0 next cycle.
REQ-040 Scenario: r_rstn low for 2 cycles mid-stream with 2 words buffered -> out_valid and r_inc fall immediately; after release, the next word delivered is the next FIFO word.
REQ-041 Scenario: random empty and out_ready for 10k cycles -> scoreboard sees an exact in-order match, and count+pend ≤ 3 holds throughout.
